// File: rtl/mipi_csi_frame_controller.sv
// Frame-level sequencer for the CSI-2 receive path: detects FS/FE/LP headers,
// gates the packet decoder to requested frames, and tracks lines and errors.
module mipi_csi_frame_controller #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hB8,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd16777215
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        data_valid_i,
  input  logic [31:0] data_i,
  input  logic        capture_req_i,
  input  logic        continuous_i,
  input  logic        err_clear_i,
  input  logic        decoder_valid_i,
  input  logic [15:0] packet_length_i,
  output logic        decoder_enable_o,
  output logic        frame_active_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic [15:0] frame_number_o,
  output logic [15:0] line_count_o,
  output logic [15:0] line_length_o,
  output logic        err_length_o,
  output logic        err_sequence_o,
  output logic        err_timeout_o
);

  typedef enum logic [1:0] {IDLE, ARMED, FRAME, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [7:0]  prev_b0;
  logic        armed, dv_q;
  logic [23:0] tmo_cnt;
  logic        hdr, is_fs, is_fe, is_lp, dv_rise, tmo_hit;
  logic        accept_fs, restart_fs, end_frame, seq_set, len_set, count_line;
  logic [15:0] wc;
  logic        unused_ecc;

  // Byte 3 of the header is ECC, which this block does not check.
  assign unused_ecc = ^data_i[31:24];

  assign hdr     = data_valid_i && (prev_b0 == SYNC_BYTE);
  assign is_fs   = hdr && (data_i[5:0] == 6'h00);
  assign is_fe   = hdr && (data_i[5:0] == 6'h01);
  assign is_lp   = hdr && ((data_i[7:0] == 8'h2B) || (data_i[7:0] == 8'h2C) ||
                           (data_i[7:0] == 8'h2D));
  assign wc      = {data_i[23:16], data_i[15:8]};
  assign dv_rise = decoder_valid_i && !dv_q;
  // Fires on the TIMEOUT_CYCLES-th cycle spent in FRAME.
  assign tmo_hit = (state == FRAME) && (tmo_cnt == TIMEOUT_CYCLES - 24'd1);

  assign decoder_enable_o = data_valid_i && (state == FRAME);
  assign frame_active_o   = (state == FRAME) || (state == DRAIN);

  always_comb begin
    state_nxt  = state;
    accept_fs  = 1'b0;
    restart_fs = 1'b0;
    end_frame  = 1'b0;
    seq_set    = 1'b0;
    case (state)
      IDLE: begin
        if (armed) state_nxt = ARMED;
        if (is_fe) seq_set = 1'b1;
      end
      ARMED: begin
        if (is_fs) begin
          state_nxt = FRAME;
          accept_fs = 1'b1;
        end
        if (is_fe || is_lp) seq_set = 1'b1;
      end
      FRAME: begin
        if (is_fs) seq_set = 1'b1;
        if (tmo_hit || is_fe) state_nxt = DRAIN;
        else if (is_fs)       restart_fs = 1'b1;
      end
      DRAIN: begin
        if (!decoder_valid_i) begin
          end_frame = 1'b1;
          state_nxt = (armed || continuous_i) ? ARMED : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign count_line = ((state == FRAME) || (state == DRAIN)) && dv_rise && !restart_fs;
  assign len_set    = count_line && (line_count_o != 16'd0) &&
                      (packet_length_i != line_length_o);

  always_ff @(negedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(negedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      prev_b0        <= '0;
      dv_q           <= 1'b0;
      armed          <= 1'b0;
      tmo_cnt        <= '0;
      frame_start_o  <= 1'b0;
      frame_end_o    <= 1'b0;
      frame_number_o <= '0;
      line_count_o   <= '0;
      line_length_o  <= '0;
      err_length_o   <= 1'b0;
      err_sequence_o <= 1'b0;
      err_timeout_o  <= 1'b0;
    end else begin
      prev_b0       <= data_valid_i ? data_i[7:0] : 8'h00;
      dv_q          <= decoder_valid_i;
      frame_start_o <= accept_fs || restart_fs;
      frame_end_o   <= end_frame;
      // A new request in the same cycle as an accepted FS arms the next frame.
      if (capture_req_i)                  armed <= 1'b1;
      else if (accept_fs && !continuous_i) armed <= 1'b0;
      if (accept_fs || restart_fs) begin
        frame_number_o <= wc;
        line_count_o   <= '0;
        line_length_o  <= '0;
        tmo_cnt        <= '0;
      end else begin
        if ((state == FRAME) && (tmo_cnt != TIMEOUT_CYCLES)) tmo_cnt <= tmo_cnt + 24'd1;
        if (count_line) begin
          if (line_count_o != 16'hFFFF) line_count_o <= line_count_o + 16'd1;
          if (line_count_o == 16'd0)    line_length_o <= packet_length_i;
        end
      end
      err_length_o   <= len_set | (err_length_o   & ~err_clear_i);
      err_sequence_o <= seq_set | (err_sequence_o & ~err_clear_i);
      err_timeout_o  <= tmo_hit | (err_timeout_o  & ~err_clear_i);
    end
  end

endmodule

// File: tb/tb_mipi_csi_frame_controller.sv
// Directed frame scenarios plus a random packet stream, all checked every cycle
// against a cycle-level reference model of the frame sequencer.
module tb_mipi_csi_frame_controller;
  localparam logic [7:0] SYNC = 8'hB8;
  localparam int TMO = 100;
  localparam int S_IDLE = 0, S_ARMED = 1, S_FRAME = 2, S_DRAIN = 3;

  logic        clk_i = 1'b0, reset_n_i = 1'b0;
  logic        data_valid_i = 1'b0, capture_req_i = 1'b0, continuous_i = 1'b0;
  logic        err_clear_i = 1'b0, decoder_valid_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [15:0] packet_length_i = '0;
  logic        decoder_enable_o, frame_active_o, frame_start_o, frame_end_o;
  logic [15:0] frame_number_o, line_count_o, line_length_o;
  logic        err_length_o, err_sequence_o, err_timeout_o;

  int tests = 0, fails = 0, n_start = 0, n_end = 0;

  mipi_csi_frame_controller #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(24'd100)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .data_valid_i(data_valid_i), .data_i(data_i),
    .capture_req_i(capture_req_i), .continuous_i(continuous_i), .err_clear_i(err_clear_i),
    .decoder_valid_i(decoder_valid_i), .packet_length_i(packet_length_i),
    .decoder_enable_o(decoder_enable_o), .frame_active_o(frame_active_o),
    .frame_start_o(frame_start_o), .frame_end_o(frame_end_o),
    .frame_number_o(frame_number_o), .line_count_o(line_count_o),
    .line_length_o(line_length_o), .err_length_o(err_length_o),
    .err_sequence_o(err_sequence_o), .err_timeout_o(err_timeout_o));

  always #5 clk_i = ~clk_i;

  // Reference model state
  int          m_st, m_cyc;
  logic [31:0] m_prev;
  logic        m_armed, m_dv_q, m_fs_p, m_fe_p, m_el, m_es, m_et;
  logic [15:0] m_fnum, m_lines, m_len;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_cyc = 0; m_prev = '0; m_armed = 0; m_dv_q = 0;
    m_fs_p = 0; m_fe_p = 0; m_el = 0; m_es = 0; m_et = 0;
    m_fnum = '0; m_lines = '0; m_len = '0;
  endtask

  // One falling-edge step of the sequencer, from the inputs currently applied.
  task automatic model_step();
    logic hdr, fs, fe, lp, rise, tmo, start, restart, seq_set, len_set;
    int nst;
    hdr  = data_valid_i && (m_prev[7:0] == SYNC);
    fs   = hdr && (data_i[5:0] == 6'h00);
    fe   = hdr && (data_i[5:0] == 6'h01);
    lp   = hdr && (data_i[7:0] inside {8'h2B, 8'h2C, 8'h2D});
    rise = decoder_valid_i && !m_dv_q;
    tmo  = (m_st == S_FRAME) && (m_cyc + 1 == TMO);
    start   = (m_st == S_ARMED) && fs;
    restart = (m_st == S_FRAME) && fs && !tmo && !fe;
    seq_set = (fs && m_st == S_FRAME) || (fe && (m_st == S_IDLE || m_st == S_ARMED)) ||
              (lp && m_st == S_ARMED);
    len_set = 1'b0;
    m_fs_p = start || restart;
    m_fe_p = 1'b0;
    nst = m_st;
    if ((m_st == S_FRAME || m_st == S_DRAIN) && rise && !restart) begin
      if (m_lines == 0) m_len = packet_length_i;
      else if (packet_length_i != m_len) len_set = 1'b1;
      if (m_lines != 16'hFFFF) m_lines = m_lines + 16'd1;
    end
    if (m_st == S_IDLE && m_armed) nst = S_ARMED;
    if (start) nst = S_FRAME;
    if (m_st == S_FRAME && (tmo || fe)) nst = S_DRAIN;
    if (m_st == S_DRAIN && !decoder_valid_i) begin
      m_fe_p = 1'b1;
      nst = (m_armed || continuous_i) ? S_ARMED : S_IDLE;
    end
    if (start || restart) begin
      m_fnum = {data_i[23:16], data_i[15:8]};
      m_lines = '0; m_len = '0; m_cyc = 0;
    end else if (m_st == S_FRAME) m_cyc++;
    m_el = len_set || (m_el && !err_clear_i);
    m_es = seq_set || (m_es && !err_clear_i);
    m_et = tmo     || (m_et && !err_clear_i);
    if (capture_req_i) m_armed = 1'b1;
    else if (start && !continuous_i) m_armed = 1'b0;
    m_dv_q = decoder_valid_i;
    m_prev = data_valid_i ? data_i : '0;
    m_st = nst;
  endtask

  task automatic check_all();
    chk1("decoder_enable", decoder_enable_o, data_valid_i && (m_st == S_FRAME));
    chk1("frame_active", frame_active_o, (m_st == S_FRAME) || (m_st == S_DRAIN));
    chk1("frame_start", frame_start_o, m_fs_p);
    chk1("frame_end", frame_end_o, m_fe_p);
    chk16("frame_number", frame_number_o, m_fnum);
    chk16("line_count", line_count_o, m_lines);
    chk16("line_length", line_length_o, m_len);
    chk1("err_length", err_length_o, m_el);
    chk1("err_sequence", err_sequence_o, m_es);
    chk1("err_timeout", err_timeout_o, m_et);
    n_start += int'(frame_start_o);
    n_end   += int'(frame_end_o);
  endtask

  task automatic tick();
    @(negedge clk_i);
    model_step();
    @(posedge clk_i);
    check_all();
  endtask

  task automatic cyc(input logic v, input logic [31:0] d);
    data_valid_i = v;
    data_i = d;
    tick();
    capture_req_i = 1'b0;
    err_clear_i = 1'b0;
  endtask

  function automatic logic [31:0] payload();
    logic [31:0] w;
    w = $urandom;
    if (w[7:0] == SYNC) w[7:0] = 8'h00;
    return w;
  endfunction

  task automatic send_hdr(input logic [7:0] di, input logic [15:0] wc);
    cyc(1'b1, {payload() & 32'hFFFF_FF00} | {24'h0, SYNC});
    cyc(1'b1, {8'h00, wc, di});
  endtask

  task automatic line(input logic [15:0] len);
    decoder_valid_i = 1'b1;
    packet_length_i = len;
    cyc(1'b1, payload());
    decoder_valid_i = 1'b0;
    cyc(1'b1, payload());
  endtask

  task automatic arm();
    capture_req_i = 1'b1;
    cyc(1'b0, '0);
    cyc(1'b0, '0);
  endtask

  task automatic finish_frame();
    send_hdr(8'h01, 16'h0);
    cyc(1'b0, '0);
    chk1("fe_pulse", frame_end_o, 1'b1);
    cyc(1'b0, '0);
  endtask

  initial begin
    logic [7:0] dis [8];
    logic hdr_next;
    int s0, e0, k;
    dis = '{8'h00, 8'h01, 8'h2B, 8'h2C, 8'h2D, 8'h40, 8'h41, 8'h12};
    model_reset();
    @(posedge clk_i);
    check_all();
    @(negedge clk_i);
    @(posedge clk_i);
    check_all();
    reset_n_i = 1'b1;

    // Single-shot frame
    arm();
    send_hdr(8'h00, 16'd5);
    chk1("t1_start", frame_start_o, 1'b1);
    chk16("t1_fnum", frame_number_o, 16'd5);
    for (int i = 0; i < 3; i++) begin
      send_hdr(8'h2B, 16'd40);
      cyc(1'b1, payload());
      line(16'd40);
    end
    s0 = n_start; e0 = n_end;
    finish_frame();
    chk16("t1_lines", line_count_o, 16'd3);
    chk16("t1_len", line_length_o, 16'd40);
    chk16("t1_starts", 16'(n_start - s0 + 1), 16'd1);
    chk16("t1_ends", 16'(n_end - e0), 16'd1);
    chk1("t1_idle", frame_active_o, 1'b0);
    chk1("t1_errs", err_length_o | err_sequence_o | err_timeout_o, 1'b0);

    // Continuous mode: back-to-back frames
    continuous_i = 1'b1;
    s0 = n_start; e0 = n_end;
    arm();
    for (int f = 1; f <= 2; f++) begin
      send_hdr(8'h00, 16'(f));
      chk16("t2_lines_clr", line_count_o, 16'd0);
      line(16'd40);
      line(16'd40);
      finish_frame();
      chk16("t2_lines", line_count_o, 16'd2);
    end
    chk16("t2_starts", 16'(n_start - s0), 16'd2);
    chk16("t2_ends", 16'(n_end - e0), 16'd2);
    chk16("t2_fnum", frame_number_o, 16'd2);
    continuous_i = 1'b0;
    send_hdr(8'h00, 16'd3);
    chk1("t2_rearmed", frame_start_o, 1'b1);
    finish_frame();

    // Length mismatch
    arm();
    send_hdr(8'h00, 16'd10);
    line(16'd40);
    line(16'd40);
    chk1("t3_len_ok", err_length_o, 1'b0);
    line(16'd36);
    chk1("t3_len_err", err_length_o, 1'b1);
    err_clear_i = 1'b1;
    cyc(1'b0, '0);
    chk1("t3_len_clr", err_length_o, 1'b0);
    finish_frame();

    // Protocol errors
    arm();
    send_hdr(8'h01, 16'h0);
    chk1("t4_fe_armed", err_sequence_o, 1'b1);
    err_clear_i = 1'b1;
    cyc(1'b0, '0);
    chk1("t4_seq_clr", err_sequence_o, 1'b0);
    send_hdr(8'h2B, 16'd40);
    chk1("t4_lp_armed", err_sequence_o, 1'b1);
    cyc(1'b1, payload());
    chk1("t4_lp_gated", decoder_enable_o, 1'b0);
    send_hdr(8'h00, 16'd7);
    cyc(1'b1, payload());
    chk1("t4_first_gated", decoder_enable_o, 1'b1);
    line(16'd40);
    chk16("t4_lines", line_count_o, 16'd1);
    send_hdr(8'h00, 16'd8);
    chk1("t4_restart", frame_start_o, 1'b1);
    chk16("t4_restart_lines", line_count_o, 16'd0);
    chk16("t4_restart_fnum", frame_number_o, 16'd8);
    finish_frame();

    // Timeout
    err_clear_i = 1'b1;
    cyc(1'b0, '0);
    arm();
    send_hdr(8'h00, 16'd9);
    k = 0;
    while (!err_timeout_o && k < 200) begin
      cyc(1'b1, payload());
      k++;
    end
    chk16("t5_tmo_cycles", 16'(k), 16'(TMO));
    cyc(1'b0, '0);
    chk1("t5_end", frame_end_o, 1'b1);

    // Reset mid-frame
    arm();
    send_hdr(8'h00, 16'd11);
    send_hdr(8'h2B, 16'd40);
    data_valid_i = 1'b1;
    data_i = payload();
    decoder_valid_i = 1'b1;
    #2 reset_n_i = 1'b0;
    #1 model_reset();
    check_all();
    chk1("t6_enable", decoder_enable_o, 1'b0);
    chk16("t6_fnum", frame_number_o, 16'd0);
    @(negedge clk_i);
    @(posedge clk_i);
    decoder_valid_i = 1'b0;
    reset_n_i = 1'b1;
    cyc(1'b0, '0);
    send_hdr(8'h00, 16'd12);
    chk1("t6_fs_ignored", frame_start_o, 1'b0);
    cyc(1'b1, payload());
    chk1("t6_still_idle", frame_active_o, 1'b0);

    // Random packet stream
    hdr_next = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] w;
      w = $urandom;
      capture_req_i = ($urandom_range(0, 39) == 0);
      err_clear_i   = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 199) == 0) continuous_i = ~continuous_i;
      if ($urandom_range(0, 3) == 0) decoder_valid_i = ~decoder_valid_i;
      packet_length_i = ($urandom_range(0, 3) == 0) ? 16'd36 : 16'd40;
      if (hdr_next) begin
        w[7:0] = dis[$urandom_range(0, 7)];
        data_valid_i = 1'b1;
        hdr_next = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        w[7:0] = SYNC;
        data_valid_i = 1'b1;
        hdr_next = 1'b1;
      end else begin
        data_valid_i = ($urandom_range(0, 9) != 0);
      end
      data_i = w;
      tick();
    end
    capture_req_i = 1'b0;
    err_clear_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
